// File: rtl/asym_fifo.sv
// Asymmetric-width synchronous FIFO: wide write/narrow read (MODE 0) or narrow write/wide read (MODE 1).
// Define ASYM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module asym_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 2,
  parameter int MODE       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  localparam int WW = (MODE == 0) ? DATA_WIDTH * RATIO : DATA_WIDTH,
  localparam int RW = (MODE == 0) ? DATA_WIDTH : DATA_WIDTH * RATIO
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [WW-1:0]         w_data,
  output logic [RW-1:0]         r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count
`ifdef ASYM_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WIN   = (MODE == 0) ? RATIO : 1;
  localparam int WOUT  = (MODE == 0) ? 1 : RATIO;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   WIN_C   = (ADDR_WIDTH + 1)'(WIN);
  localparam logic [ADDR_WIDTH:0]   WOUT_C  = (ADDR_WIDTH + 1)'(WOUT);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  // Pointer steps truncate to the pointer width so RATIO == DEPTH steps wrap to the same slot.
  localparam logic [ADDR_WIDTH-1:0] WIN_P   = ADDR_WIDTH'(WIN);
  localparam logic [ADDR_WIDTH-1:0] WOUT_P  = ADDR_WIDTH'(WOUT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full        = (DEPTH_C - count) < WIN_C;
  assign empty       = count < WOUT_C;
  assign almost_full = count >= AF_C;
  assign wr_ok       = wr && !full;
  assign rd_ok       = rd && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + WIN_P;
      if (rd_ok) r_ptr <= r_ptr + WOUT_P;
      count <= count + (wr_ok ? WIN_C : '0) - (rd_ok ? WOUT_C : '0);
    end
  end

  // Lowest address always carries the least-significant slice of a wide word.
  generate
    if (MODE == 0) begin : g_wide_wr
      always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
          for (int k = 0; k < RATIO; k++) begin
            mem[w_ptr + ADDR_WIDTH'(k)] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      assign r_data = mem[r_ptr];
    end else begin : g_wide_rd
      always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
          mem[w_ptr] <= w_data;
        end
      end
      always_comb begin
        r_data = '0;
        for (int k = 0; k < RATIO; k++) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[r_ptr + ADDR_WIDTH'(k)];
        end
      end
    end
  endgenerate

`ifdef ASYM_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_asym_fifo.sv
// Bench for asym_fifo: one MODE 0 and one MODE 1 instance checked every cycle against byte-queue models.
module tb_asym_fifo;

  logic        clk;
  logic        reset;
  logic        wr0, rd0, wr1, rd1;
  logic [15:0] w_data0;
  logic [7:0]  r_data0;
  logic [7:0]  w_data1;
  logic [15:0] r_data1;
  logic        full0, empty0, af0, full1, empty1, af1;
  logic [3:0]  count0, count1;
`ifdef ASYM_FIFO_ERR_EN
  logic        overflow0, underflow0, overflow1, underflow1;
`endif

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit ovfM0, udfM0, ovfM1, udfM1;

  asym_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .wr(wr0), .rd(rd0), .w_data(w_data0), .r_data(r_data0),
    .full(full0), .empty(empty0), .almost_full(af0), .count(count0)
`ifdef ASYM_FIFO_ERR_EN
    , .overflow(overflow0), .underflow(underflow0)
`endif
  );

  asym_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .wr(wr1), .rd(rd1), .w_data(w_data1), .r_data(r_data1),
    .full(full1), .empty(empty1), .almost_full(af1), .count(count1)
`ifdef ASYM_FIFO_ERR_EN
    , .overflow(overflow1), .underflow(underflow1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle on both instances, then advance the queue models by the FIFO rules.
  task automatic applyStimulus(input bit rs, input bit w0, input bit r0, input logic [15:0] d0,
                               input bit w1, input bit r1, input logic [7:0] d1);
    bit f, e;
    reset = rs; wr0 = w0; rd0 = r0; w_data0 = d0; wr1 = w1; rd1 = r1; w_data1 = d1;
    @(posedge clk);
    if (rs) begin
      q0.delete(); q1.delete();
      ovfM0 = 0; udfM0 = 0; ovfM1 = 0; udfM1 = 0;
    end else begin
      f = (8 - q0.size()) < 2;
      e = q0.size() < 1;
      if (w0 && f) ovfM0 = 1;
      if (r0 && e) udfM0 = 1;
      if (r0 && !e) void'(q0.pop_front());
      if (w0 && !f) begin
        q0.push_back(d0[7:0]);
        q0.push_back(d0[15:8]);
      end
      f = q1.size() >= 8;
      e = q1.size() < 2;
      if (w1 && f) ovfM1 = 1;
      if (r1 && e) udfM1 = 1;
      if (r1 && !e) begin
        void'(q1.pop_front());
        void'(q1.pop_front());
      end
      if (w1 && !f) q1.push_back(d1);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("count0", int'(count0), q0.size());
      checkOutput("full0", int'(full0), int'(q0.size() > 6));
      checkOutput("empty0", int'(empty0), int'(q0.size() == 0));
      checkOutput("af0", int'(af0), int'(q0.size() >= 6));
      if (q0.size() >= 1) checkOutput("rdata0", int'(r_data0), int'(q0[0]));
      checkOutput("count1", int'(count1), q1.size());
      checkOutput("full1", int'(full1), int'(q1.size() >= 8));
      checkOutput("empty1", int'(empty1), int'(q1.size() < 2));
      checkOutput("af1", int'(af1), int'(q1.size() >= 6));
      if (q1.size() >= 2) checkOutput("rdata1", int'(r_data1), int'({q1[1], q1[0]}));
`ifdef ASYM_FIFO_ERR_EN
      checkOutput("ovf0", int'(overflow0), int'(ovfM0));
      checkOutput("udf0", int'(underflow0), int'(udfM0));
      checkOutput("ovf1", int'(overflow1), int'(ovfM1));
      checkOutput("udf1", int'(underflow1), int'(udfM1));
`endif
    end
  end

  initial begin
    reset = 1'b0; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; w_data0 = '0; w_data1 = '0;
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 8'h0);
    checkEn = 1;
    checkOutput("rst_count", int'(count0), 0);
    checkOutput("rst_empty", int'(empty0), 1);
    checkOutput("rst_full", int'(full0), 0);
    checkOutput("rst_af", int'(af0), 0);

    // Single wide word split into two narrow reads.
    applyStimulus(0, 1, 0, 16'hBBAA, 0, 0, 8'h0);
    checkOutput("w1_count", int'(count0), 2);
    checkOutput("w1_head", int'(r_data0), 8'hAA);
    applyStimulus(0, 0, 1, 16'h0, 0, 0, 8'h0);
    checkOutput("r1_head", int'(r_data0), 8'hBB);
    applyStimulus(0, 0, 1, 16'h0, 0, 0, 8'h0);
    checkOutput("r2_empty", int'(empty0), 1);

    // Fill to full, attempt an extra write, then simultaneous wr/rd at full.
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(0, 1, 0, 16'h2211, 0, 0, 8'h0);
    applyStimulus(0, 1, 0, 16'h4433, 0, 0, 8'h0);
    applyStimulus(0, 1, 0, 16'h6655, 0, 0, 8'h0);
    checkOutput("af_at6", int'(af0), 1);
    applyStimulus(0, 1, 0, 16'h8877, 0, 0, 8'h0);
    checkOutput("full_count", int'(count0), 8);
    checkOutput("full_flag", int'(full0), 1);
    applyStimulus(0, 1, 0, 16'h1234, 0, 0, 8'h0);
    checkOutput("ovw_count", int'(count0), 8);
    checkOutput("ovw_head", int'(r_data0), 8'h11);
    applyStimulus(0, 1, 1, 16'hDEAD, 0, 0, 8'h0);
    checkOutput("wr_rd_full_count", int'(count0), 7);
    checkOutput("wr_rd_full_head", int'(r_data0), 8'h22);
`ifdef ASYM_FIFO_ERR_EN
    checkOutput("ovf_set", int'(overflow0), 1);
`endif
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 16'h0, 0, 0, 8'h0);
    checkOutput("drained", int'(empty0), 1);

    // Streaming write/read pairs across the pointer wrap.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 1, {8'(2*i+1), 8'(2*i)} ^ 16'hA55A, 0, 0, 8'h0);
      checkOutput("stream_bound", int'(count0 <= 4'd8), 1);
    end

    // Narrow writes assembling one wide read word, then a read on empty.
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 8'h0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, 8'h11);
    checkOutput("m1_empty_one", int'(empty1), 1);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, 8'h22);
    checkOutput("m1_empty_two", int'(empty1), 0);
    checkOutput("m1_rdata", int'(r_data1), 16'h2211);
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 8'h0);
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 8'h0);
`ifdef ASYM_FIFO_ERR_EN
    checkOutput("m1_udf", int'(underflow1), 1);
`endif

    // Reset in the middle of operation with a write pending.
    applyStimulus(0, 1, 0, 16'h0201, 0, 0, 8'h0);
    applyStimulus(0, 1, 0, 16'h0403, 0, 0, 8'h0);
    applyStimulus(0, 1, 0, 16'h0605, 0, 0, 8'h0);
    applyStimulus(0, 0, 1, 16'h0, 0, 0, 8'h0);
    checkOutput("pre_rst_count", int'(count0), 5);
    applyStimulus(1, 1, 0, 16'hFFFF, 1, 0, 8'hFF);
    checkOutput("mid_rst_count", int'(count0), 0);
    checkOutput("mid_rst_empty", int'(empty0), 1);
`ifdef ASYM_FIFO_ERR_EN
    checkOutput("mid_rst_ovf", int'(overflow0), 0);
    checkOutput("mid_rst_udf1", int'(underflow1), 0);
`endif

    // Randomized traffic: write-heavy half then read-heavy half, rare resets.
    for (int i = 0; i < 800; i++) begin
      int wp;
      int rp;
      wp = (i < 400) ? 70 : 35;
      rp = (i < 400) ? 35 : 70;
      applyStimulus($urandom_range(0, 79) == 0,
                    $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 16'($urandom),
                    $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
    end

    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
